// File: rtl/soc_design_debounce_pkg.sv
// soc_design_debounce_pkg: shared state encoding and default constants for the input debouncer
package soc_design_debounce_pkg;
  typedef enum logic {ST_STABLE, ST_CHECKING} deb_state_e;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
endpackage

// File: rtl/soc_design_debounce_bit.sv
// soc_design_debounce_bit: one-bit synchronizer, debounce FSM and registered edge pulses
module soc_design_debounce_bit
  import soc_design_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic w_s;
  deb_state_e r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic w_clean_nx;
  assign w_s = r_sync[SYNC_STAGES-1];
  // plain shift chain: no logic between stages so each flop can resolve metastability
  always_ff @(posedge clk or posedge reset)
    if (reset) r_sync <= {SYNC_STAGES{INIT_LEVEL}};
    else r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  // state, counter, clean level and pulses all update together so pulses align with clean
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      o_clean <= INIT_LEVEL;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      o_clean <= w_clean_nx;
      o_rise  <= w_clean_nx & ~o_clean;
      o_fall  <= ~w_clean_nx & o_clean;
    end
  // accept a change only after it has persisted for DEBOUNCE_CYCLES sampled cycles
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = '0;
    w_clean_nx = o_clean;
    if (r_state == ST_STABLE) begin
      if (w_s != o_clean) begin
        if (DEBOUNCE_CYCLES == 1) w_clean_nx = w_s;
        else begin
          w_state_nx = ST_CHECKING;
          w_cnt_nx   = CW'(1);
        end
      end
    end else if (w_s == o_clean) w_state_nx = ST_STABLE;
    else if (r_cnt == LAST) begin
      w_clean_nx = w_s;
      w_state_nx = ST_STABLE;
    end else w_cnt_nx = r_cnt + CW'(1);
  end
endmodule

// File: rtl/soc_design_input_debounce.sv
// soc_design_input_debounce: per-bit synchronize and debounce of raw board inputs for the PIO
module soc_design_input_debounce
  import soc_design_debounce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit INIT_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    soc_design_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT_LEVEL(INIT_LEVEL)
    ) u_bit (
      .clk(clk),
      .reset(reset),
      .i_raw(raw_in[g]),
      .o_clean(clean_out[g]),
      .o_rise(rise_pulse[g]),
      .o_fall(fall_pulse[g])
    );
  end
  assign any_change = |(rise_pulse | fall_pulse);
endmodule

// File: tb/tb_soc_design_input_debounce.sv
// tb_soc_design_input_debounce: directed table plus random stimulus against a streak-based model
module tb_soc_design_input_debounce;
  localparam int W = 8, SS = 2, DC = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] clean_out, rise_pulse, fall_pulse;
  logic any_change;
  int errs = 0, checks = 0;
  int any_cnt = 0, rise_cnt = 0;
  logic [W-1:0] hist[$];
  logic [W-1:0] m_clean = '0, m_rise = '0, m_fall = '0;
  int streak[W];
  typedef struct {
    logic [W-1:0] raw;
    int           n;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  soc_design_input_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .INIT_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .clean_out(clean_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_clean = '0; m_rise = '0; m_fall = '0;
    foreach (streak[i]) streak[i] = 0;
  endtask

  // a bit's level is accepted once the synchronized input has disagreed with it for DC edges in a row
  task automatic model_edge(input logic [W-1:0] r);
    logic [W-1:0] s, nc;
    s = (hist.size() >= SS) ? hist[hist.size()-SS] : '0;
    hist.push_back(r);
    if (hist.size() > SS) void'(hist.pop_front());
    nc = m_clean;
    for (int i = 0; i < W; i++) begin
      if (s[i] != m_clean[i]) begin
        streak[i]++;
        if (streak[i] == DC) begin
          nc[i] = s[i];
          streak[i] = 0;
        end
      end else streak[i] = 0;
    end
    m_rise = nc & ~m_clean;
    m_fall = ~nc & m_clean;
    m_clean = nc;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(raw_in);
    #1;
    check("cycle", {7'd0, clean_out, rise_pulse, fall_pulse, any_change},
          {7'd0, m_clean, m_rise, m_fall, |(m_rise | m_fall)});
    any_cnt += int'(any_change);
    rise_cnt += int'(rise_pulse[0]);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {8'd0, clean_out, rise_pulse, fall_pulse, any_change}, '0);
    @(negedge clk);
    reset = 1'b0;
    vecs = '{
      '{8'h00, 20, 8'h00},
      '{8'h01, 5, 8'h00}, '{8'h01, 1, 8'h01},
      '{8'h00, 10, 8'h00},
      '{8'h01, 3, 8'h00}, '{8'h00, 10, 8'h00},
      '{8'h01, 1, 8'h00}, '{8'h00, 1, 8'h00}, '{8'h01, 1, 8'h00}, '{8'h00, 1, 8'h00},
      '{8'h01, 5, 8'h00}, '{8'h01, 1, 8'h01},
      '{8'h00, 10, 8'h00},
      '{8'hA5, 5, 8'h00}, '{8'hA5, 1, 8'hA5}, '{8'hA5, 5, 8'hA5},
      '{8'h00, 5, 8'hA5}, '{8'h00, 1, 8'h00}, '{8'h00, 5, 8'h00},
      '{8'h01, 6, 8'h01}, '{8'h00, 4, 8'h01}
    };
    for (int v = 0; v < vecs.size(); v++) begin
      raw_in = vecs[v].raw;
      if (v == 4) rise_cnt = 0;
      if (v == 6) begin
        check("glitch_no_rise", rise_cnt, 0);
        rise_cnt = 0;
      end
      if (v == 12) check("bounce_one_rise", rise_cnt, 1);
      if (v == 13) any_cnt = 0;
      if (v == 16) check("a5_any_once", any_cnt, 1);
      if (v == 19) check("a5_fall_any_once", any_cnt, 2);
      for (int c = 0; c < vecs[v].n; c++) step();
      check($sformatf("vec%0d_clean", v), clean_out, vecs[v].exp);
    end
    // now mid-CHECKING with cnt=2 toward 0; an async reset must drop clean at once
    #2;
    reset = 1'b1;
    raw_in = 8'h01;
    model_reset();
    #1;
    check("async_reset_clean", {8'd0, clean_out, rise_pulse, fall_pulse, any_change}, '0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("post_reset_wait", clean_out, 8'h00);
    step();
    check("post_reset_clean", clean_out, 8'h01);
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] m;
      for (int i = 0; i < W; i++) m[i] = ($urandom_range(0, 5) == 0);
      raw_in = raw_in ^ m;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        model_reset();
        #2;
        check("rand_reset", {8'd0, clean_out, rise_pulse, fall_pulse, any_change}, '0);
        reset = 1'b0;
      end
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
